nv_nvdla_cdma_wt_wgs_ctrl: RTL and testbench

NV_NVDLA_CDMA_WT_WGS_CTRL -- requirements
Module: NV_NVDLA_CDMA_WT_wgs_ctrl

---
 rtl/nv_nvdla_cdma_wt_wgs_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_nv_nvdla_cdma_wt_wgs_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cdma_wt_wgs_ctrl.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_wgs_ctrl
// Weight-group-size (wgs) entry generator for the CDMA weight path.
// Splits a layer's kernels into groups. Emits one wgs entry per group
// toward the downstream wgs fifo. Issue is throttled by a credit
// counter of entries not yet retired by the consumer.
//
// Optional feature:
//   NV_NVDLA_CDMA_WT_WGS_CTRL_PERF_EN - when defined, builds the stall
//   cycle counter behind dp2reg_wgs_stall. When undefined, that output
//   is tied to zero and no counter flops are built.
//
// Parameters:
//   CREDIT_MAX  max outstanding wgs entries (downstream fifo depth, 1..32)
//
// Ports:
//   clk                      core clock, rising edge
//   reset_                   asynchronous active-low reset
//   op_en                    layer start pulse, honored only in IDLE
//   reg2dp_kernel_num        total kernels in layer minus 1
//   reg2dp_kernel_per_group  kernels per group minus 1
//   wgs_wr_req               entry valid toward wgs fifo (registered)
//   wgs_wr_ready             fifo accepts entry
//   wgs_wr_data              {6'b0, last_group, kernel_cnt_m1[12:0], group_idx[11:0]}
//   wgs_release              one-cycle pulse, consumer retired one entry
//   busy                     high while not IDLE
//   op_done                  one-cycle pulse at layer completion
//   credit_err               sticky, release seen with nothing outstanding
//   dp2reg_wgs_stall         stall cycle counter (zero unless PERF_EN)
// ---------------------------------------------------------------------------
module nv_nvdla_cdma_wt_wgs_ctrl #(
  parameter int unsigned CREDIT_MAX = 32
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        op_en,
  input  logic [12:0] reg2dp_kernel_num,
  input  logic [12:0] reg2dp_kernel_per_group,
  output logic        wgs_wr_req,
  input  logic        wgs_wr_ready,
  output logic [31:0] wgs_wr_data,
  input  logic        wgs_release,
  output logic        busy,
  output logic        op_done,
  output logic        credit_err,
  output logic [31:0] dp2reg_wgs_stall
);

  localparam int unsigned KER_W = 13;
  localparam int unsigned REM_W = 14;
  localparam int unsigned GRP_W = 12;
  localparam int unsigned OUT_W = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OUT_W-1:0] CREDIT_LIM = OUT_W'(CREDIT_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [5:0]       rsvd;
    logic             last_group;
    logic [KER_W-1:0] kernel_cnt_m1;
    logic [GRP_W-1:0] group_idx;
  } wgs_entry_t;

  logic [1:0]       state;
  logic [KER_W-1:0] kpg;
  logic [REM_W-1:0] remaining;
  logic [GRP_W-1:0] group_idx;
  logic [OUT_W-1:0] outstanding;

  logic [1:0]       state_nxt;
  logic [KER_W-1:0] kpg_nxt;
  logic [REM_W-1:0] remaining_nxt;
  logic [GRP_W-1:0] group_idx_nxt;
  logic             req_nxt;
  logic [31:0]      data_nxt;
  logic             busy_nxt;
  logic             op_done_nxt;
  logic             credit_err_nxt;

  logic             accept_c;
  logic             rel_ok_c;
  logic [OUT_W-1:0] out_nxt_c;
  logic [REM_W-1:0] grp_size_c;
  logic [REM_W-1:0] cur_cnt_c;
  logic             cur_last_c;
  logic [REM_W-1:0] nxt_rem_c;
  logic [GRP_W-1:0] nxt_gidx_c;
  logic [REM_W-1:0] nxt_cnt_c;
  wgs_entry_t       nxt_entry_c;
  logic             issue_ok_c;

  // Credit bookkeeping: a release is only honored if something is (or is becoming) outstanding.
  assign accept_c  = wgs_wr_req && wgs_wr_ready;
  assign rel_ok_c  = wgs_release && ((outstanding != '0) || accept_c);
  assign out_nxt_c = (accept_c && !rel_ok_c) ? outstanding + OUT_W'(1) :
                     (!accept_c && rel_ok_c) ? outstanding - OUT_W'(1) :
                                               outstanding;

  // Group sizing for the entry currently presented.
  assign grp_size_c = REM_W'(kpg) + REM_W'(1);
  assign cur_cnt_c  = (grp_size_c < remaining) ? grp_size_c : remaining;
  assign cur_last_c = (remaining <= grp_size_c);

  // Candidate for the next presented entry, accounting for this cycle's accept.
  assign nxt_rem_c  = accept_c ? remaining - cur_cnt_c : remaining;
  assign nxt_gidx_c = accept_c ? group_idx + GRP_W'(1) : group_idx;
  assign nxt_cnt_c  = (grp_size_c < nxt_rem_c) ? grp_size_c : nxt_rem_c;

  always_comb begin
    nxt_entry_c               = '0;
    nxt_entry_c.last_group    = (nxt_rem_c <= grp_size_c);
    nxt_entry_c.kernel_cnt_m1 = KER_W'(nxt_cnt_c - REM_W'(1));
    nxt_entry_c.group_idx     = nxt_gidx_c;
  end

  // Issue only with kernels left and a free credit after this cycle's traffic.
  assign issue_ok_c = (nxt_rem_c != '0) && (out_nxt_c < CREDIT_LIM);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    kpg_nxt        = kpg;
    remaining_nxt  = remaining;
    group_idx_nxt  = group_idx;
    req_nxt        = wgs_wr_req;
    data_nxt       = wgs_wr_data;
    credit_err_nxt = credit_err ||
                     (wgs_release && (outstanding == '0) && !accept_c);

    case (state)
      IDLE: begin
        if (op_en) begin
          state_nxt     = RUN;
          kpg_nxt       = reg2dp_kernel_per_group;
          remaining_nxt = REM_W'(reg2dp_kernel_num) + REM_W'(1);
          group_idx_nxt = '0;
          req_nxt       = 1'b0;
          data_nxt      = '0;
        end
      end
      RUN: begin
        remaining_nxt = nxt_rem_c;
        group_idx_nxt = nxt_gidx_c;
        if (accept_c && cur_last_c) begin
          state_nxt = DRAIN;
          req_nxt   = 1'b0;
          data_nxt  = '0;
        end else if (!wgs_wr_req || accept_c) begin
          // A presented entry is held until accepted; otherwise present the next one.
          req_nxt = issue_ok_c;
          if (issue_ok_c) begin
            data_nxt = nxt_entry_c;
          end
        end
      end
      DRAIN: begin
        if ((outstanding == '0) && !accept_c) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        data_nxt  = '0;
      end
    endcase

    busy_nxt    = (state_nxt != IDLE);
    op_done_nxt = (state_nxt == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      kpg         <= '0;
      remaining   <= '0;
      group_idx   <= '0;
      outstanding <= '0;
      wgs_wr_req  <= 1'b0;
      wgs_wr_data <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      credit_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      kpg         <= kpg_nxt;
      remaining   <= remaining_nxt;
      group_idx   <= group_idx_nxt;
      outstanding <= out_nxt_c;
      wgs_wr_req  <= req_nxt;
      wgs_wr_data <= data_nxt;
      busy        <= busy_nxt;
      op_done     <= op_done_nxt;
      credit_err  <= credit_err_nxt;
    end
  end

`ifdef NV_NVDLA_CDMA_WT_WGS_CTRL_PERF_EN
  logic             stall_c;
  logic [CNT_W-1:0] stall_cnt;

  // Stalled: entry refused by the fifo, or an entry is due but no credit is free.
  assign stall_c = (state == RUN) &&
                   ((wgs_wr_req && !wgs_wr_ready) ||
                    (!wgs_wr_req && (nxt_rem_c != '0) && !(out_nxt_c < CREDIT_LIM)));

  // Saturating stall counter, cleared when a layer starts.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && op_en) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign dp2reg_wgs_stall = stall_cnt;
`else
  assign dp2reg_wgs_stall = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_wgs_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_cdma_wt_wgs_ctrl
// Self-checking bench: table of layer configurations with hand-computed
// entry counts, plus directed sequences for credit limit, fifo backpressure,
// release corner cases, op_en during RUN and mid-layer reset.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cdma_wt_wgs_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        op_en;
  logic [12:0] reg2dp_kernel_num;
  logic [12:0] reg2dp_kernel_per_group;
  logic        wgs_wr_req;
  logic        wgs_wr_ready;
  logic [31:0] wgs_wr_data;
  logic        wgs_release;
  logic        busy;
  logic        op_done;
  logic        credit_err;
  logic [31:0] dp2reg_wgs_stall;

`ifdef NV_NVDLA_CDMA_WT_WGS_CTRL_PERF_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  nv_nvdla_cdma_wt_wgs_ctrl #(.CREDIT_MAX(32)) dut (
    .clk                     (clk),
    .reset_                  (reset_),
    .op_en                   (op_en),
    .reg2dp_kernel_num       (reg2dp_kernel_num),
    .reg2dp_kernel_per_group (reg2dp_kernel_per_group),
    .wgs_wr_req              (wgs_wr_req),
    .wgs_wr_ready            (wgs_wr_ready),
    .wgs_wr_data             (wgs_wr_data),
    .wgs_release             (wgs_release),
    .busy                    (busy),
    .op_done                 (op_done),
    .credit_err              (credit_err),
    .dp2reg_wgs_stall        (dp2reg_wgs_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] kn;
    logic [12:0] kpg;
    int          n;
    logic [12:0] last_m1;
  } vec_t;

  vec_t        tbl [7];
  int          n_chk = 0;
  int          n_err = 0;
  int          acc_cnt;
  int          rel_cnt;
  int          done_cnt;
  bit          auto_rel;
  logic [31:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: drive release, record accepts/op_done as seen before the edge.
  task automatic cyc(input bit force_rel);
    wgs_release = force_rel || (auto_rel && (acc_cnt > rel_cnt));
    if (wgs_release) rel_cnt++;
    if (wgs_wr_req && wgs_wr_ready) begin
      acc_cnt++;
      q.push_back(wgs_wr_data);
    end
    if (op_done) done_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    q.delete();
    acc_cnt  = 0;
    rel_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic start_layer(input logic [12:0] kn, input logic [12:0] kpg, input string nm);
    int lat;
    reg2dp_kernel_num       = kn;
    reg2dp_kernel_per_group = kpg;
    op_en = 1'b1;
    cyc(1'b0);
    op_en = 1'b0;
    lat = 0;
    while (!wgs_wr_req && lat < 4) begin
      cyc(1'b0);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat <= 1), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      cyc(1'b0);
      n++;
    end
    repeat (3) cyc(1'b0);
    chk({nm, "_done"}, 32'(done_cnt), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_entries(input string nm, input logic [12:0] kpg, input int n,
                               input logic [12:0] last_m1);
    chk({nm, "_n"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      logic        last;
      logic [31:0] e;
      last = (i == n - 1);
      e    = {6'b0, last, (last ? last_m1 : kpg), 12'(i)};
      chk($sformatf("%s_e%0d", nm, i), q[i], e);
    end
  endtask

  initial begin
    logic [31:0] d0;
    int          n;
    int          saw;

    reset_                  = 1'b0;
    op_en                   = 1'b0;
    reg2dp_kernel_num       = '0;
    reg2dp_kernel_per_group = '0;
    wgs_wr_ready            = 1'b0;
    wgs_release             = 1'b0;
    auto_rel                = 1'b0;
    clear_sb();

    // {kernel_num, kernel_per_group, entries, last entry count-1}
    tbl[0] = '{13'd99, 13'd31, 4,  13'd3};
    tbl[1] = '{13'd0,  13'd0,  1,  13'd0};
    tbl[2] = '{13'd7,  13'd7,  1,  13'd7};
    tbl[3] = '{13'd8,  13'd7,  2,  13'd0};
    tbl[4] = '{13'd9,  13'd2,  4,  13'd0};
    tbl[5] = '{13'd5,  13'd12, 1,  13'd5};
    tbl[6] = '{13'd63, 13'd0,  64, 13'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(wgs_wr_req), 32'd0);
    chk("rst_data",  wgs_wr_data, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(op_done), 32'd0);
    chk("rst_cerr",  32'(credit_err), 32'd0);
    chk("rst_stall", dp2reg_wgs_stall, 32'd0);
    chk("rst_out",   32'(dut.outstanding), 32'd0);
    reset_ = 1'b1;
    cyc(1'b0);

    // Table: ready always high, immediate release
    for (int t = 0; t < 7; t++) begin
      clear_sb();
      wgs_wr_ready = 1'b1;
      auto_rel     = 1'b1;
      start_layer(tbl[t].kn, tbl[t].kpg, $sformatf("t%0d", t));
      wait_done($sformatf("t%0d", t));
      check_entries($sformatf("t%0d", t), tbl[t].kpg, tbl[t].n, tbl[t].last_m1);
    end

    // Credit limit: 40 single-kernel groups, no release
    clear_sb();
    wgs_wr_ready = 1'b1;
    auto_rel     = 1'b0;
    start_layer(13'd39, 13'd0, "crd");
    repeat (60) cyc(1'b0);
    chk("crd_acc32", 32'(acc_cnt), 32'd32);
    chk("crd_req",   32'(wgs_wr_req), 32'd0);
    chk("crd_busy",  32'(busy), 32'd1);
    cyc(1'b1);
    repeat (10) cyc(1'b0);
    chk("crd_acc33", 32'(acc_cnt), 32'd33);
    chk("crd_req2",  32'(wgs_wr_req), 32'd0);
    auto_rel = 1'b1;
    wait_done("crd");
    check_entries("crd", 13'd0, 40, 13'd0);

    // Fifo backpressure: data held for 5 refused cycles
    clear_sb();
    wgs_wr_ready            = 1'b0;
    auto_rel                = 1'b0;
    reg2dp_kernel_num       = 13'd9;
    reg2dp_kernel_per_group = 13'd2;
    op_en = 1'b1;
    cyc(1'b0);
    op_en = 1'b0;
    chk("stl_clr", dp2reg_wgs_stall, 32'd0);
    cyc(1'b0);
    chk("stl_req", 32'(wgs_wr_req), 32'd1);
    d0 = wgs_wr_data;
    chk("stl_d0", d0, {6'b0, 1'b0, 13'd2, 12'd0});
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      chk($sformatf("stl_hreq%0d", i), 32'(wgs_wr_req), 32'd1);
      chk($sformatf("stl_hdat%0d", i), wgs_wr_data, d0);
    end
    chk("stl_cnt", dp2reg_wgs_stall, 32'(STALL_EXP));
    wgs_wr_ready = 1'b1;
    auto_rel     = 1'b1;
    wait_done("stl");
    check_entries("stl", 13'd2, 4, 13'd0);
    chk("stl_cnt2", dp2reg_wgs_stall, 32'(STALL_EXP));

    // Simultaneous accept and release at outstanding 3; release at zero
    clear_sb();
    wgs_wr_ready = 1'b1;
    auto_rel     = 1'b0;
    start_layer(13'd9, 13'd0, "sim");
    n = 0;
    while (acc_cnt < 3 && n < 20) begin
      cyc(1'b0);
      n++;
    end
    chk("sim_out3", 32'(dut.outstanding), 32'd3);
    chk("sim_req",  32'(wgs_wr_req), 32'd1);
    cyc(1'b1);
    chk("sim_out3b", 32'(dut.outstanding), 32'd3);
    chk("sim_acc4",  32'(acc_cnt), 32'd4);
    auto_rel = 1'b1;
    wait_done("sim");
    chk("sim_out0",  32'(dut.outstanding), 32'd0);
    chk("sim_cerr0", 32'(credit_err), 32'd0);
    auto_rel = 1'b0;
    cyc(1'b1);
    chk("sim_cerr1", 32'(credit_err), 32'd1);
    chk("sim_outz",  32'(dut.outstanding), 32'd0);
    cyc(1'b0);
    chk("sim_cerrs", 32'(credit_err), 32'd1);

    // op_en while running is ignored
    clear_sb();
    wgs_wr_ready = 1'b1;
    auto_rel     = 1'b1;
    start_layer(13'd99, 13'd31, "ign");
    cyc(1'b0);
    reg2dp_kernel_num       = 13'd3;
    reg2dp_kernel_per_group = 13'd0;
    op_en = 1'b1;
    cyc(1'b0);
    op_en = 1'b0;
    wait_done("ign");
    check_entries("ign", 13'd31, 4, 13'd3);

    // Reset mid-layer after 2 entries
    clear_sb();
    wgs_wr_ready = 1'b1;
    auto_rel     = 1'b0;
    start_layer(13'd9, 13'd0, "mrs");
    n = 0;
    while (acc_cnt < 2 && n < 20) begin
      cyc(1'b0);
      n++;
    end
    reset_ = 1'b0;
    #1;
    chk("mrs_busy", 32'(busy), 32'd0);
    chk("mrs_req",  32'(wgs_wr_req), 32'd0);
    chk("mrs_data", wgs_wr_data, 32'd0);
    chk("mrs_out",  32'(dut.outstanding), 32'd0);
    chk("mrs_cerr", 32'(credit_err), 32'd0);
    cyc(1'b0);
    reset_ = 1'b1;
    clear_sb();
    saw = 0;
    repeat (10) begin
      if (wgs_wr_req) saw++;
      cyc(1'b0);
    end
    chk("mrs_noreq", 32'(saw), 32'd0);
    chk("mrs_noacc", 32'(acc_cnt), 32'd0);
    clear_sb();
    auto_rel = 1'b1;
    start_layer(13'd1, 13'd0, "mrs2");
    wait_done("mrs2");
    check_entries("mrs2", 13'd0, 2, 13'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
